ofmap_collect_buffer: RTL
=========================

# ofmap_collect_buffer

Output-side counterpart of the vertical ifmap buffer. The PE array emits results as a skewed byte stream, one 8-bit ofmap byte per column per cycle for 4 cycles. This block collects those bytes and re-packs each column's 4 bytes into one 32-bit word. It then drains the words, in column order, to the GLB write path through a valid/ready handshake. Byte order is the inverse of the ifmap loader: the first byte received per column lands in word bits [7:0], and the fourth in [31:24].

## Interface
- COL_NUM, 32, number of PE columns / packed words per pass
- BYTES_PER_COL, 4, bytes captured per column per pass
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; clears all state
- start  input  1  one-cycle pulse; arms a new collection pass
- ofmap_in  input  COL_NUM*8  column c byte on [c*8 +: 8]
- ofmap_valid  input  COL_NUM  per-column byte-valid
- out_word  output  32  packed word of column out_col
- out_col  output  5  column index of out_word
- out_valid  output  1  out_word holds a complete column word
- out_ready  input  1  GLB writer accepts out_word
- busy  output  1  pass in progress
- done  output  1  one-cycle pulse after last word accepted
- overflow  output  1  sticky; a byte arrived for a full column or outside a pass

## Operation
- FSM states: IDLE, COLLECT, DONE.
  - IDLE: on start, go to COLLECT. Clear all per-column byte counters and full flags, and set ptr=0.
  - COLLECT: capture and drain run concurrently. After the handshake on ptr=COL_NUM-1, go to DONE.
  - DONE: assert done for 1 cycle, then go to IDLE.
- Capture, in COLLECT only: for each column c, when ofmap_valid[c]=1 and cnt[c]<4:
  - word[c] <= {ofmap_in[c*8+:8], word[c][31:8]}
  - cnt[c]++
  - cnt[c] reaching 4 sets full[c].
- Per-column capture is independent, so any skew and any gaps between a column's bytes are legal.
- Error cases, both setting overflow; neither alters stored data:
  - ofmap_valid[c] while full[c]: byte dropped.
  - Any ofmap_valid in IDLE or DONE: byte dropped. This includes the cycle in which start is sampled.
- Drain:
  - out_valid = (state==COLLECT) && full[ptr].
  - out_word = word[ptr]; out_col = ptr.
  - Handshake = out_valid && out_ready; on handshake, ptr++.
  - Columns always drain in order 0..COL_NUM-1, even if a later column fills first.
- start while busy: ignored.
- overflow: cleared only by reset or by an accepted start.
- Reset values: out_word 0, out_col 0, out_valid 0, busy 0, done 0, overflow 0, state IDLE, all counters and full flags 0.

## Timing
- busy: 1 from the cycle after start through the DONE cycle.
- Capture: a byte sampled at edge N is in word[c] after edge N.
- Word availability: full[c] is registered, so out_valid for a column can first assert in the cycle after its 4th byte is sampled.
- Holding: while out_valid=1 and out_ready=0, out_word and out_col hold stable. The column is full, so no write can alter it.
- Nominal skewed pass with out_ready=1:
  - start at cycle 0; column c valid in cycles 1+c .. 4+c.
  - out_valid first asserts at cycle 5.
  - One word per cycle; the last handshake is at cycle 36.
  - done at cycle 37; IDLE at cycle 38.
- Reset mid-pass: takes effect at the next edge and returns all state to reset values. The partial pass is discarded and no done is produced.

## Structure
- Shared package holds:
  - COL_NUM, BYTES_PER_COL, and the byte/word width localparams.
  - Collector state enum typedef.
- Sub-module col_packer, one per column via generate:
  - 3-bit counter, 32-bit shift register, full flag.
  - Inputs: clear, valid, byte.
  - Outputs: word, full, overflow strobe.
- Top level holds the FSM, drain pointer, output mux, and overflow OR-reduction.

## Test plan
- Nominal skewed pass: column c bytes = {4c+0, 4c+1, 4c+2, 4c+3}, skewed as in Timing; out_ready=1. Expect words 0x03020100, 0x07060504, … in column order 0..31, with done at cycle 37.
- Back-pressure: out_ready low in cycles 5–9, then toggled 1/0. Expect out_word and out_col stable while stalled, and no word lost or duplicated.
- Out-of-order fill: column 5 filled before column 0. Expect out_valid=0 until column 0 is full, then column 0 delivered first.
- Overflow: a 5th byte 0xFF to column 2, plus ofmap_valid asserted during IDLE. Expect overflow=1, column 2 word unchanged, and overflow cleared by the next start.
- Reset mid-pass: reset asserted at cycle 20. Expect all outputs 0 next cycle and no done. A new start then completes a clean pass.
- start during busy: a second start at cycle 10. Expect it ignored, the pass unaffected, and a single done pulse.

Source files
------------

// File: rtl/ofmap_collect_buffer_pkg.sv
// Shared parameters and types for the ofmap collect buffer.
package ofmap_collect_buffer_pkg;

    localparam int COL_NUM       = 32;
    localparam int BYTES_PER_COL = 4;
    localparam int BYTE_W        = 8;
    localparam int WORD_W        = BYTE_W * BYTES_PER_COL;
    localparam int PTR_W         = $clog2(COL_NUM);
    localparam int CNT_W         = $clog2(BYTES_PER_COL) + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } collect_state_e;

    // Extract the byte belonging to column col from the flat PE-array bus.
    function automatic logic [BYTE_W-1:0] col_byte(
        input logic [COL_NUM*BYTE_W-1:0] bus_data,
        input int                        col
    );
        return bus_data[col*BYTE_W +: BYTE_W];
    endfunction

endpackage

// File: rtl/ofmap_collect_buffer_if.sv
// Bus bundle between the PE array / GLB writer and the collect buffer.
interface ofmap_collect_buffer_if;
    import ofmap_collect_buffer_pkg::*;

    logic                        start;
    logic [COL_NUM*BYTE_W-1:0]   ofmap_in;
    logic [COL_NUM-1:0]          ofmap_valid;
    logic [WORD_W-1:0]           out_word;
    logic [PTR_W-1:0]            out_col;
    logic                        out_valid;
    logic                        out_ready;
    logic                        busy;
    logic                        done;
    logic                        overflow;

    // Collect-buffer side.
    modport slave (
        input  start, ofmap_in, ofmap_valid, out_ready,
        output out_word, out_col, out_valid, busy, done, overflow
    );

    // Environment side: PE array plus GLB writer.
    modport master (
        output start, ofmap_in, ofmap_valid, out_ready,
        input  out_word, out_col, out_valid, busy, done, overflow
    );

endinterface

// File: rtl/ofmap_collect_buffer_col_packer.sv
// One column's byte packer: shifts in up to four bytes, first byte ends in [7:0].
module ofmap_collect_buffer_col_packer
    import ofmap_collect_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    input  logic              valid,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word,
    output logic              full,
    output logic              overflow
);

    logic [CNT_W-1:0]  cnt_r;
    logic [WORD_W-1:0] word_r;
    logic              full_r;

    // Capture a byte while the pass is open and the column still has room.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_r  <= {CNT_W{1'b0}};
            word_r <= {WORD_W{1'b0}};
            full_r <= 1'b0;
        end else if (enable && valid && !full_r) begin
            word_r <= {byte_in, word_r[WORD_W-1:BYTE_W]};
            cnt_r  <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            full_r <= (cnt_r == CNT_W'(BYTES_PER_COL - 1));
        end else begin
            word_r <= word_r;
            cnt_r  <= cnt_r;
            full_r <= full_r;
        end
    end

    // A byte is dropped either outside a pass or once the column is full.
    always_comb begin
        overflow = 1'b0;
        if (valid) begin
            overflow = !enable || full_r;
        end else begin
            overflow = 1'b0;
        end
    end

    assign word = word_r;
    assign full = full_r;

endmodule

// File: rtl/ofmap_collect_buffer.sv
// Collects skewed per-column ofmap bytes into 32-bit words and drains them
// in column order over a valid/ready handshake.
module ofmap_collect_buffer
    import ofmap_collect_buffer_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    ofmap_collect_buffer_if.slave  bus
);

    collect_state_e    state_r;
    logic [PTR_W-1:0]  ptr_r;
    logic              busy_r;
    logic              done_r;
    logic              overflow_r;

    logic [COL_NUM-1:0] full_s;
    logic [COL_NUM-1:0] col_ovf_s;
    logic [WORD_W-1:0]  word_s [COL_NUM];
    logic               start_accept_s;
    logic               collect_s;
    logic               out_valid_s;
    logic               handshake_s;

    assign start_accept_s = (state_r == ST_IDLE) && bus.start;
    assign collect_s      = (state_r == ST_COLLECT);

    for (genvar gi = 0; gi < COL_NUM; gi++) begin : g_col
        ofmap_collect_buffer_col_packer u_packer (
            .clk      (clk),
            .reset    (reset),
            .clear    (start_accept_s),
            .enable   (collect_s),
            .valid    (bus.ofmap_valid[gi]),
            .byte_in  (col_byte(bus.ofmap_in, gi)),
            .word     (word_s[gi]),
            .full     (full_s[gi]),
            .overflow (col_ovf_s[gi])
        );
    end

    // Drain view: only the pointed-to column may be offered, and only when full.
    always_comb begin
        out_valid_s = 1'b0;
        handshake_s = 1'b0;
        if (collect_s) begin
            out_valid_s = full_s[ptr_r];
            handshake_s = full_s[ptr_r] && bus.out_ready;
        end else begin
            out_valid_s = 1'b0;
            handshake_s = 1'b0;
        end
    end

    // Pass sequencing, drain pointer and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            ptr_r      <= {PTR_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            // A byte dropped in the start cycle still counts as an error.
            overflow_r <= (start_accept_s ? 1'b0 : overflow_r) | (|col_ovf_s);
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        state_r <= ST_COLLECT;
                        ptr_r   <= {PTR_W{1'b0}};
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    if (handshake_s) begin
                        ptr_r <= ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
                        if (ptr_r == PTR_W'(COL_NUM - 1)) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_COLLECT;
                        end
                    end else begin
                        state_r <= ST_COLLECT;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    ptr_r   <= {PTR_W{1'b0}};
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid = out_valid_s;
    assign bus.out_word  = word_s[ptr_r];
    assign bus.out_col   = ptr_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.overflow  = overflow_r;

endmodule
